i2s_rx_deserializer: RTL
========================

# i2s_rx_deserializer

Deserializes the PCM9211 I2S receive stream (bclk, lrclk, data) into parallel left/right sample pairs in the system `clk` domain. It sits directly upstream of the audio processing stage and feeds it one stereo pair per frame over a valid/ready handshake. It also flags frame errors and consumer overruns.

## Interface
- `SAMPLE_W`, 24: bits kept per channel, MSB-first; `SAMPLE_W` ≤ 32.
- `MIN_SLOT`, 16: minimum legal bclk count per half-frame.
- `MAX_SLOT`, 64: maximum legal bclk count per half-frame.
- `clk` in 1: system clock; must be ≥ 4× bclk frequency.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: receiver enable; low forces IDLE.
- `i2s_bclk` in 1: bit clock, asynchronous to `clk`.
- `i2s_lrclk` in 1: word select, asynchronous; low = left.
- `i2s_d` in 1: serial data, asynchronous.
- `sample_l` out `SAMPLE_W`: left sample, two's complement.
- `sample_r` out `SAMPLE_W`: right sample, two's complement.
- `sample_valid` out 1: output pair is valid.
- `sample_ready` in 1: consumer accepts the pair.
- `frame_err` out 1: one-cycle pulse when a slot length is illegal.
- `overrun` out 1: one-cycle pulse when an unconsumed pair is overwritten.
- `locked` out 1: high while in the LEFT or RIGHT state.

## Operation
- Input path:
  - All three inputs pass through 2-FF synchronizers.
  - `bclk_rise` is a one-cycle strobe on a rising edge of the synchronized bclk.
  - lrclk and d are sampled only on `bclk_rise`.
- Slot boundary: on a `bclk_rise`, a sampled lrclk that differs from the previous sample marks a boundary.
  - The data bit sampled on that edge is the LSB of the previous slot.
  - The next rising edge carries the MSB of the new slot (standard I2S one-bit delay).
- Shift rule: the first `SAMPLE_W` bits of a slot are shifted in; extra bits are ignored. A slot shorter than `SAMPLE_W` is zero-padded at the LSBs.
- Slot counter: 7 bits, reset at each boundary, incremented on each `bclk_rise`. At a boundary, a count < `MIN_SLOT` or > `MAX_SLOT` is an error.
- States:
  - IDLE: entered on reset or while `enable` = 0. Leaves to SYNC when `enable` = 1.
  - SYNC: waits for an lrclk high→low boundary, then goes to LEFT. No counting error checks apply before the first boundary.
  - LEFT: on a low→high boundary, latch the left word and go to RIGHT.
  - RIGHT: on a high→low boundary, the pair is complete; load the output registers and return to LEFT.
  - LEFT or RIGHT with a slot-length error: pulse `frame_err`, discard the partial pair, go to SYNC.
- Output buffer (one-deep):
  - Load sets `sample_valid`.
  - Handshake completes on a `clk` edge where `sample_valid` and `sample_ready` are both 1; this clears `sample_valid`.
  - Load while `sample_valid` = 1 and no handshake that cycle: overwrite the pair, pulse `overrun`, keep `sample_valid` = 1.
  - Load in the same cycle as a handshake: the old pair is consumed, the new pair is loaded, `sample_valid` stays 1, no overrun.
- `enable` falling: on the next `clk` go to IDLE, clear `sample_valid`, discard partial data. `sample_l` and `sample_r` hold their values.
- Reset, including mid-frame: all outputs 0, state IDLE, shift register and counter cleared.

## Timing
- `bclk_rise` is asserted 3 `clk` cycles after the i2s_bclk pin edge (2 sync stages + 1 edge register).
- `sample_valid` rises 1 `clk` after the `bclk_rise` that closes the right slot, i.e. 4 `clk` after the pin edge.
- `frame_err` fires 1 `clk` after the offending boundary strobe.
- `overrun` fires in the cycle the pair is overwritten.
- `sample_l`, `sample_r` and `sample_valid` are registered outputs with no combinational path from `sample_ready`.
- Throughput: one pair per I2S frame; the consumer has a full frame to assert `sample_ready`.

## Configuration
- Macro: `I2S_RX_ERR_CNT_EN`.
- Defined: adds output `err_count` [15:0], a saturating count of `frame_err` plus `overrun` pulses.
  - Both pulses in one cycle count as 2.
  - Cleared by reset, holds at 16'hFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `audipus_i2s_pkg` holds:
  - the state enum (IDLE, SYNC, LEFT, RIGHT);
  - default `SAMPLE_W`, `MIN_SLOT` and `MAX_SLOT` constants;
  - the slot counter width.
- Sub-module `i2s_rx_sync`: 2-FF synchronizers for bclk, lrclk and d, plus the `bclk_rise` strobe generator. Instantiated once.

## Test plan
- 64-bclk frames, left 24'h123456, right 24'hABCDEF, `sample_ready` = 1 → one `sample_valid` pulse per frame with the exact values; first pair valid 4 `clk` after the closing bclk edge; `locked` = 1.
- `sample_ready` held 0 across two frames → `overrun` pulses once, the output holds the second pair, `sample_valid` stays 1.
- Truncated 10-bclk slot injected mid-stream → `frame_err` pulse, `locked` = 0, the partial pair is dropped, valid output resumes after the next high→low lrclk boundary.
- 32-bclk frames (16-bit slots) with left 16'h8001 → `sample_l` = 24'h800100 (LSBs zero-padded).
- `reset` asserted mid-right-slot, then released → all outputs 0 immediately, state IDLE; the first valid pair appears only after a full left+right frame.
- With `I2S_RX_ERR_CNT_EN` defined: 3 frame errors + 2 overruns → `err_count` = 5.

Source files
------------

// File: rtl/i2s_rx_deserializer_pkg.sv
// audipus_i2s_pkg: shared state enum and default sizing for the I2S receive path.
// Holds the FSM states, default SAMPLE_W/MIN_SLOT/MAX_SLOT and the slot counter width.
package audipus_i2s_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;
  localparam int SAMPLE_W_DEF = 24;
  localparam int MIN_SLOT_DEF = 16;
  localparam int MAX_SLOT_DEF = 64;
  localparam int CNT_W = 7;
endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// i2s_rx_deserializer_if: stereo sample valid/ready bus between receiver and consumer.
// master (receiver): drives sample_l, sample_r, sample_valid; reads sample_ready.
// slave (consumer): reads the pair and valid; drives sample_ready.
interface i2s_rx_deserializer_if
  import audipus_i2s_pkg::*;
#(parameter int SAMPLE_W = SAMPLE_W_DEF);
  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic sample_valid;
  logic sample_ready;
  modport master (output sample_l, sample_r, sample_valid, input sample_ready);
  modport slave (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_rx_deserializer_sync.sv
// i2s_rx_sync: 2-FF synchronizers for bclk/lrclk/d plus a registered bclk rising-edge strobe.
// Inputs: clk, reset, bclk, lrclk, d (asynchronous pins).
// Outputs: bclk_rise (one-cycle strobe), lr and dat (aligned with the strobe).
module i2s_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic lrclk,
  input  logic d,
  output logic bclk_rise,
  output logic lr,
  output logic dat
);
  logic [2:0] b;
  logic [1:0] l, s;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      b <= '0;
      l <= '0;
      s <= '0;
      bclk_rise <= 1'b0;
      lr <= 1'b0;
      dat <= 1'b0;
    end else begin
      b <= {b[1:0], bclk};
      l <= {l[0], lrclk};
      s <= {s[0], d};
      bclk_rise <= b[1] & ~b[2];
      lr <= l[1];
      dat <= s[1];
    end
endmodule

// File: rtl/i2s_rx_deserializer.sv
// i2s_rx_deserializer: I2S receive deserializer producing left/right pairs on a valid/ready bus.
// Ports: clk, reset (async, active high), enable, i2s_bclk/i2s_lrclk/i2s_d pins,
// pcm (i2s_rx_deserializer_if.master), frame_err and overrun pulses, locked.
// Optional macro I2S_RX_ERR_CNT_EN adds err_count, a saturating count of error pulses.
module i2s_rx_deserializer
  import audipus_i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int MIN_SLOT = MIN_SLOT_DEF,
  parameter int MAX_SLOT = MAX_SLOT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic i2s_bclk,
  input  logic i2s_lrclk,
  input  logic i2s_d,
  i2s_rx_deserializer_if.master pcm,
  output logic frame_err,
  output logic overrun,
  output logic locked
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);
  localparam logic [CNT_W-1:0] W_C = CNT_W'(SAMPLE_W);
  localparam logic [CNT_W:0] MIN_C = (CNT_W+1)'(MIN_SLOT);
  localparam logic [CNT_W:0] MAX_C = (CNT_W+1)'(MAX_SLOT);
  state_t state, state_nx;
  logic rise, lr, d, lr_prev, bnd, bad_len, load_l, load_o, err;
  logic [CNT_W-1:0] cnt, shamt;
  logic [CNT_W:0] len;
  logic [SAMPLE_W-1:0] sr, sr_nx, word, left_w;
  i2s_rx_sync u_sync (
    .clk(clk), .reset(reset), .bclk(i2s_bclk), .lrclk(i2s_lrclk), .d(i2s_d),
    .bclk_rise(rise), .lr(lr), .dat(d)
  );
  // cnt is the bit index within the slot; the boundary edge itself carries the old slot's LSB,
  // so the slot length seen at a boundary is cnt + 1.
  assign bnd = rise && (lr != lr_prev);
  assign len = {1'b0, cnt} + 1'b1;
  assign bad_len = len < MIN_C || len > MAX_C;
  assign sr_nx = cnt < W_C ? {sr[SAMPLE_W-2:0], d} : sr;
  assign shamt = cnt + 1'b1 < W_C ? W_C - cnt - 1'b1 : '0;
  assign word = sr_nx << shamt;
  assign locked = state == LEFT || state == RIGHT;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    load_l = 1'b0;
    load_o = 1'b0;
    err = 1'b0;
    if (!enable) state_nx = IDLE;
    else
      case (state)
        IDLE: state_nx = SYNC;
        SYNC: state_nx = bnd && !lr ? LEFT : SYNC;
        LEFT, RIGHT:
          if (bnd) begin
            err = bad_len;
            load_l = !bad_len && state == LEFT;
            load_o = !bad_len && state == RIGHT;
            state_nx = bad_len ? SYNC : state == LEFT ? RIGHT : LEFT;
          end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lr_prev <= 1'b0;
      cnt <= '0;
      sr <= '0;
      left_w <= '0;
      pcm.sample_l <= '0;
      pcm.sample_r <= '0;
      pcm.sample_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rise) lr_prev <= lr;
      if (!enable || state == IDLE) begin
        cnt <= '0;
        sr <= '0;
      end else if (rise) begin
        cnt <= bnd ? '0 : &cnt ? cnt : cnt + 1'b1;
        sr <= bnd ? '0 : sr_nx;
      end
      if (load_l) left_w <= word;
      if (load_o) begin
        pcm.sample_l <= left_w;
        pcm.sample_r <= word;
      end
      pcm.sample_valid <= enable && (load_o || (pcm.sample_valid && !pcm.sample_ready));
      frame_err <= err;
      overrun <= load_o && pcm.sample_valid && !pcm.sample_ready;
    end
`ifdef I2S_RX_ERR_CNT_EN
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_count} + {16'd0, frame_err} + {16'd0, overrun};
  always_ff @(posedge clk or posedge reset)
    if (reset) err_count <= '0;
    else err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
endmodule
